// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: frame RAM read port bundle.
// master = frame reader (issues reads), slave = RAM (returns data).
interface vga_frame_reader_if #(
  parameter int RAM_WIDTH   = 32,
  parameter int ADRESS_BITS = 15
);
  logic                   rd_en;
  logic [ADRESS_BITS-1:0] adress;
  logic [RAM_WIDTH-1:0]   data;

  modport master (
    output rd_en,
    output adress,
    input  data
  );

  modport slave (
    input  rd_en,
    input  adress,
    output data
  );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: prefetching frame RAM -> VGA pixel streamer.
// Optional FRAME_READER_DOUBLE_BUFFER_EN adds buf_sel and a second frame.
module vga_frame_reader #(
  parameter int RAM_WIDTH  = 32,
  parameter int PIXEL_BITS = 8,
  parameter int H_PIXELS   = 480,
  parameter int V_PIXELS   = 360,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  visible,
`ifdef FRAME_READER_DOUBLE_BUFFER_EN
  input  logic                  buf_sel,
`endif
  vga_frame_reader_if.master    ram,
  output logic [PIXEL_BITS-1:0] pixel_out,
  output logic                  underrun
);

  localparam int PPW         = RAM_WIDTH / PIXEL_BITS;
  localparam int FRAME_WORDS = H_PIXELS * V_PIXELS / PPW;
  localparam int WA          = $clog2(FRAME_WORDS);
`ifdef FRAME_READER_DOUBLE_BUFFER_EN
  localparam int AB          = WA + 1;
`else
  localparam int AB          = WA;
`endif
  localparam int IW          = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                state;
  logic [RAM_WIDTH-1:0]  fifo [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            count;
  logic [RD_LATENCY-1:0] vld;
  logic [2:0]            in_flight;
  logic [IW-1:0]         idx;
  logic [AB-1:0]         base;
  logic [AB-1:0]         frame_base;
  logic [AB-1:0]         last_adr;
  logic                  room;
  logic                  empty;
  logic                  push;
  logic                  take;
  logic                  pop;
  logic                  blank;
  logic                  starve;
  logic [RAM_WIDTH-1:0]  head;
  logic [PIXEL_BITS-1:0] px_lane [PPW];

`ifdef FRAME_READER_DOUBLE_BUFFER_EN
  assign frame_base = buf_sel ? AB'(FRAME_WORDS) : '0;
`else
  assign frame_base = '0;
`endif

  assign last_adr = base + AB'(FRAME_WORDS - 1);

  // Reads already issued, including the one on the bus this cycle.
  always_comb begin
    in_flight = 3'(ram.rd_en);
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + 3'(vld[i]);
    end
  end

  assign room   = (4'(count) + 4'(in_flight)) < 4'd4;
  assign empty  = (count == 3'd0);
  assign push   = vld[RD_LATENCY-1] && !frame_start;
  assign blank  = !frame_start && !visible;
  assign starve = !frame_start && visible && empty;
  assign take   = !frame_start && visible && !empty;
  assign pop    = take && (idx == IW'(PPW - 1));

  assign head = fifo[rd_ptr];

  for (genvar g = 0; g < PPW; g++) begin : g_lane
    assign px_lane[g] = head[g*PIXEL_BITS +: PIXEL_BITS];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= ram.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ram.rd_en  <= 1'b0;
      ram.adress <= '0;
      base       <= '0;
      vld        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idx        <= '0;
      pixel_out  <= '0;
      underrun   <= 1'b0;
    end else begin
      if (frame_start) begin
        state      <= RUN;
        base       <= frame_base;
        ram.adress <= frame_base;
        ram.rd_en  <= 1'b1;
        vld        <= '0;
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        ram.rd_en <= (state == RUN) && room;
        vld       <= (vld << 1) | RD_LATENCY'(ram.rd_en);
        count     <= count + 3'(push) - 3'(pop);
        if (ram.rd_en) begin
          ram.adress <= (ram.adress == last_adr) ?
                        base : ram.adress + AB'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
      end

      unique case (1'b1)
        frame_start: begin
          idx       <= '0;
          pixel_out <= '0;
          underrun  <= 1'b0;
        end
        blank: begin
          pixel_out <= '0;
        end
        // Starved: hold the index so the pixel is not lost.
        starve: begin
          pixel_out <= '0;
          underrun  <= 1'b1;
        end
        take: begin
          pixel_out <= px_lane[idx];
          idx       <= pop ? '0 : idx + IW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: table-driven check of vga_frame_reader.
// dut0 uses RD_LATENCY=1, dut1 uses RD_LATENCY=3.
module tb_vga_frame_reader;

  localparam int RW = 32;
  localparam int PB = 8;
  localparam int HP = 8;
  localparam int VP = 2;
  localparam int FW = HP * VP / (RW / PB);
`ifdef FRAME_READER_DOUBLE_BUFFER_EN
  localparam int AW = $clog2(FW) + 1;
`else
  localparam int AW = $clog2(FW);
`endif

  typedef struct {
    bit         d;
    bit         fs;
    bit         vis;
    bit         bs;
    bit         lg;
    logic [7:0] px;
    bit         un;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fs0, vis0, fs1, vis1, bsel;
  logic [PB-1:0] px0, px1;
  logic          un0, un1;

  vec_t          vq[$];
  logic [AW-1:0] alog[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_reader_if #(.RAM_WIDTH(RW), .ADRESS_BITS(AW)) ram0 ();
  vga_frame_reader_if #(.RAM_WIDTH(RW), .ADRESS_BITS(AW)) ram1 ();

  vga_frame_reader #(
    .RAM_WIDTH(RW), .PIXEL_BITS(PB), .H_PIXELS(HP),
    .V_PIXELS(VP), .RD_LATENCY(1)
  ) dut0 (
    .clk(clk), .rst(rst), .frame_start(fs0), .visible(vis0),
`ifdef FRAME_READER_DOUBLE_BUFFER_EN
    .buf_sel(bsel),
`endif
    .ram(ram0), .pixel_out(px0), .underrun(un0)
  );

  vga_frame_reader #(
    .RAM_WIDTH(RW), .PIXEL_BITS(PB), .H_PIXELS(HP),
    .V_PIXELS(VP), .RD_LATENCY(3)
  ) dut1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .visible(vis1),
`ifdef FRAME_READER_DOUBLE_BUFFER_EN
    .buf_sel(bsel),
`endif
    .ram(ram1), .pixel_out(px1), .underrun(un1)
  );

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {4{b}} + 32'h03020100;
  endfunction

  logic [31:0] d1a, d1b;

  always @(posedge clk) begin
    ram0.data <= ram_word(ram0.adress);
    d1a       <= ram_word(ram1.adress);
    d1b       <= d1a;
    ram1.data <= d1b;
  end

  function automatic void add(input bit d, input bit fs, input bit vis,
                              input logic [7:0] px, input bit un,
                              input bit lg, input bit bs);
    vec_t e;
    e.d = d; e.fs = fs; e.vis = vis; e.px = px;
    e.un = un; e.lg = lg; e.bs = bs;
    vq.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    fs0 = 1'b0; vis0 = 1'b0; fs1 = 1'b0; vis1 = 1'b0; bsel = 1'b0;
  endtask

  task automatic drive_vec(input vec_t e);
    drive_idle();
    bsel = e.bs;
    if (e.d) begin fs1 = e.fs; vis1 = e.vis; end
    else     begin fs0 = e.fs; vis0 = e.vis; end
  endtask

  task automatic check_vec(input vec_t e, input int n);
    logic [7:0]    apx;
    logic          aun, ard;
    logic [AW-1:0] aad;
    if (e.d) begin apx = px1; aun = un1; ard = ram1.rd_en; aad = ram1.adress; end
    else     begin apx = px0; aun = un0; ard = ram0.rd_en; aad = ram0.adress; end
    n_cmp++;
    if (apx !== e.px || aun !== e.un) begin
      n_bad++;
      $display("FAIL vec%0d dut%0d: pixel_out=%h underrun=%b, required %h/%b",
               n, e.d, apx, aun, e.px, e.un);
    end
    if (e.lg && ard === 1'b1) alog.push_back(aad);
  endtask

  task automatic run_table();
    int n;
    n = vq.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(vq[i-1], i - 1);
      if (i < n) drive_vec(vq[i]);
      else       drive_idle();
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    // Reset held, then idle with no frame_start.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rst_rd_en",  32'(ram0.rd_en),  32'd0);
      chk("rst_adress", 32'(ram0.adress), 32'd0);
      chk("rst_pixel",  32'(px0),         32'd0);
      chk("rst_under",  32'(un0),         32'd0);
      chk("rst_rd_en3", 32'(ram1.rd_en),  32'd0);
      if (c == 2) rst = 1'b0;
    end

    // Full frame: 16 visible pixels, read log over 24 cycles.
    add(0, 1, 0, 8'h00, 0, 1, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 16; k++) add(0, 0, 1, 8'(k/4 + k%4), 0, 1, 0);
    for (int c = 0; c < 4; c++) add(0, 0, 0, 8'h00, 0, 1, 0);
    alog.delete();
    run_table();
    chk("frame_reads", 32'(alog.size()), 32'd8);
    foreach (alog[i]) chk("frame_adress", 32'(alog[i]), 32'(i % 4));

    // Blanking: 4 on, 5 off, 4 on.
    add(0, 1, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 8'(k), 0, 0, 0);
    for (int c = 0; c < 5; c++) add(0, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 8'(1 + k), 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0);

    // Underrun right after frame_start, sticky until next frame_start.
    add(0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 0, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 1, 8'h00, 1, 0, 0);
    add(0, 0, 1, 8'h01, 1, 0, 0);
    add(0, 1, 1, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0);

    // RD_LATENCY=3: restart with reads in flight.
    add(1, 1, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 4; c++) add(1, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(1, 0, 1, 8'(k/4 + k%4), 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0);
    run_table();

`ifdef FRAME_READER_DOUBLE_BUFFER_EN
    begin
      int dbx[5] = '{4, 5, 6, 7, 4};
      add(0, 1, 0, 8'h00, 0, 1, 1);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 0, 1, 1'(c));
      for (int k = 0; k < 8; k++) add(0, 0, 1, 8'(4 + k/4 + k%4), 0, 1, 1'(k));
      for (int c = 0; c < 2; c++) add(0, 0, 0, 8'h00, 0, 0, 0);
      alog.delete();
      run_table();
      chk("db_reads", 32'(alog.size()), 32'd5);
      foreach (alog[i]) if (i < 5) chk("db_adress", 32'(alog[i]), 32'(dbx[i]));
    end
`endif

    // Reset mid-frame overrides a visible consume.
    add(0, 1, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h01, 0, 0, 0);
    run_table();
    rst  = 1'b1;
    vis0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_pixel",  32'(px0),         32'd0);
    chk("mid_rst_under",  32'(un0),         32'd0);
    chk("mid_rst_rd_en",  32'(ram0.rd_en),  32'd0);
    chk("mid_rst_adress", 32'(ram0.adress), 32'd0);
    rst  = 1'b0;
    vis0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_rd_en", 32'(ram0.rd_en), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
